pc_next_unit: RTL and testbench

- Parametrised program-counter / next-address unit for the fetch stage.
- Holds the PC register and advances it every non-stalled cycle.
- Computes sequential, region-jump, PC-relative branch and register-indirect targets.
- Jump target is {pc upper region, imm, 2'b00}. Adds a return-address stack (RAS) for call/return.

---
 rtl/pc_next_unit.sv | 150 +++++++++++++++
 tb/tb_pc_next_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_next_unit.sv
// pc_next_unit: program-counter / next-address unit for the fetch stage.
// Holds the PC register and selects the next PC among sequential, region
// jump, PC-relative branch, register-indirect and return-stack targets.
// A small circular return-address stack (RAS) backs call/return.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   stall      in   hold PC, redirect and RAS; clears ras_miss
//   op_valid   in   op/imm/br_taken/rs_val are meaningful (else SEQ)
//   op         in   0=SEQ 1=JUMP 2=JAL 3=BRANCH 4=JR 5=RET (6/7 = SEQ)
//   imm        in   jump index / branch offset (low BR_W bits, word units)
//   br_taken   in   branch condition (BRANCH only)
//   rs_val     in   register operand (JR target, RET fallback)
//   pc         out  current PC (registered)
//   pc_plus4   out  pc + 4 (combinational from pc only)
//   redirect   out  last PC update was non-sequential (registered)
//   ras_count  out  number of valid RAS entries
//   ras_miss   out  one-cycle pulse: RET executed with an empty RAS
module pc_next_unit #(
   parameter int              XLEN      = 32,
   parameter int              IMM_W     = 26,
   parameter int              BR_W      = 16,
   parameter int              RAS_DEPTH = 4,
   parameter logic [XLEN-1:0] RESET_PC  = '0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         stall,
   input  logic                         op_valid,
   input  logic [2:0]                   op,
   input  logic [IMM_W-1:0]             imm,
   input  logic                         br_taken,
   input  logic [XLEN-1:0]              rs_val,
   output logic [XLEN-1:0]              pc,
   output logic [XLEN-1:0]              pc_plus4,
   output logic                         redirect,
   output logic [$clog2(RAS_DEPTH):0]   ras_count,
   output logic                         ras_miss
);

   localparam int PW = $clog2(RAS_DEPTH);
   localparam int CW = PW + 1;

   localparam logic [2:0] OP_SEQ    = 3'd0;
   localparam logic [2:0] OP_JUMP   = 3'd1;
   localparam logic [2:0] OP_JAL    = 3'd2;
   localparam logic [2:0] OP_BRANCH = 3'd3;
   localparam logic [2:0] OP_JR     = 3'd4;
   localparam logic [2:0] OP_RET    = 3'd5;

   localparam logic [XLEN-1:0] FOUR    = XLEN'(4);
   localparam logic [PW-1:0]   PTR_ONE = PW'(1);
   localparam logic [CW-1:0]   CNT_ONE = CW'(1);
   localparam logic [CW-1:0]   CNT_MAX = CW'(RAS_DEPTH);

   // RAS storage; ras_ptr points at the next free slot, so top = ras_ptr-1.
   // When full, ras_ptr lands on the oldest entry, which a push overwrites.
   logic [XLEN-1:0] ras_mem [RAS_DEPTH];
   logic [PW-1:0]   ras_ptr;
   logic [PW-1:0]   ras_top;

   logic [2:0]      eop;
   logic [XLEN-1:0] jump_tgt, br_off, br_tgt, jr_tgt, next_pc;
   logic            nxt_redirect, push, pop, miss;

   // Low bits of rs_val are always discarded (targets are word aligned).
   logic unused_rs;
   assign unused_rs = ^rs_val[1:0];

   assign pc_plus4 = pc + FOUR;
   assign ras_top  = ras_ptr - PTR_ONE;

   // Region comes from the current pc, not pc+4.
   assign jump_tgt = {pc[XLEN-1:IMM_W+2], imm, 2'b00};
   assign br_off   = {{(XLEN-BR_W-2){imm[BR_W-1]}}, imm[BR_W-1:0], 2'b00};
   assign br_tgt   = pc_plus4 + br_off;
   assign jr_tgt   = {rs_val[XLEN-1:2], 2'b00};

   always_comb begin
      eop          = op_valid ? op : OP_SEQ;
      next_pc      = pc_plus4;
      nxt_redirect = 1'b0;
      push         = 1'b0;
      pop          = 1'b0;
      miss         = 1'b0;
      case (eop)
         OP_JUMP: begin
            next_pc      = jump_tgt;
            nxt_redirect = 1'b1;
         end
         OP_JAL: begin
            next_pc      = jump_tgt;
            nxt_redirect = 1'b1;
            push         = 1'b1;
         end
         OP_BRANCH: begin
            if (br_taken) begin
               next_pc      = br_tgt;
               nxt_redirect = 1'b1;
            end
         end
         OP_JR: begin
            next_pc      = jr_tgt;
            nxt_redirect = 1'b1;
         end
         OP_RET: begin
            nxt_redirect = 1'b1;
            if (ras_count != '0) begin
               next_pc = ras_mem[ras_top];
               pop     = 1'b1;
            end else begin
               // Empty stack: fall back to the register target.
               next_pc = jr_tgt;
               miss    = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc        <= RESET_PC;
         redirect  <= 1'b0;
         ras_count <= '0;
         ras_ptr   <= '0;
         ras_miss  <= 1'b0;
      end else if (stall) begin
         ras_miss  <= 1'b0;
      end else begin
         pc       <= next_pc;
         redirect <= nxt_redirect;
         ras_miss <= miss;
         if (push) begin
            ras_ptr <= ras_ptr + PTR_ONE;
            if (ras_count != CNT_MAX) ras_count <= ras_count + CNT_ONE;
         end else if (pop) begin
            ras_ptr   <= ras_ptr - PTR_ONE;
            ras_count <= ras_count - CNT_ONE;
         end
      end
   end

   // Contents need no reset; count/pointer define validity.
   always_ff @(posedge clk) begin
      if (!rst && !stall && push) ras_mem[ras_ptr] <= pc_plus4;
   end

endmodule

// File: tb/tb_pc_next_unit.sv
// Self-checking bench for pc_next_unit (RESET_PC=0x1000, RAS_DEPTH=4).
// Each test task builds a table of cycles; expected outputs are pushed to a
// scoreboard queue when a cycle is driven and popped after the clock edge.
module tb_pc_next_unit;

   localparam logic [2:0] SEQ = 3'd0, JUMP = 3'd1, JAL = 3'd2,
                          BR = 3'd3, JR = 3'd4, RET = 3'd5;

   logic        clk = 1'b0;
   logic        rst = 1'b1, stall = 1'b0, op_valid = 1'b0, br_taken = 1'b0;
   logic [2:0]  op = 3'd0;
   logic [25:0] imm = '0;
   logic [31:0] rs_val = '0;
   logic [31:0] pc, pc_plus4;
   logic        redirect, ras_miss;
   logic [2:0]  ras_count;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [31:0] pc; logic redir; logic [2:0] cnt; logic miss;
   } exp_t;

   typedef struct packed {
      logic r; logic s; logic v; logic [2:0] o; logic [25:0] i; logic b;
      logic [31:0] rv; exp_t e;
   } row_t;

   exp_t exp_q[$];
   row_t rows[$];

   pc_next_unit #(
      .XLEN(32), .IMM_W(26), .BR_W(16), .RAS_DEPTH(4), .RESET_PC(32'h0000_1000)
   ) dut (
      .clk(clk), .rst(rst), .stall(stall), .op_valid(op_valid), .op(op),
      .imm(imm), .br_taken(br_taken), .rs_val(rs_val), .pc(pc),
      .pc_plus4(pc_plus4), .redirect(redirect), .ras_count(ras_count),
      .ras_miss(ras_miss)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   function automatic row_t mk(input logic r, input logic s, input logic v,
                               input logic [2:0] o, input logic [25:0] i,
                               input logic b, input logic [31:0] rv,
                               input logic [31:0] epc, input logic er,
                               input logic [2:0] ec, input logic em);
      row_t t;
      t.r = r; t.s = s; t.v = v; t.o = o; t.i = i; t.b = b; t.rv = rv;
      t.e.pc = epc; t.e.redir = er; t.e.cnt = ec; t.e.miss = em;
      return t;
   endfunction

   // Drive one cycle of stimulus and record what should appear after the edge.
   task automatic apply(input row_t t);
      rst = t.r; stall = t.s; op_valid = t.v; op = t.o; imm = t.i;
      br_taken = t.b; rs_val = t.rv;
      exp_q.push_back(t.e);
   endtask

   task automatic test_reset();
      exp_t e;
      rows = {};
      rows.push_back(mk(1,0,0,SEQ,0,0,0, 32'h1000,0,0,0));
      rows.push_back(mk(1,0,1,JUMP,26'h3,0,0, 32'h1000,0,0,0));
      rows.push_back(mk(0,0,1,SEQ,0,0,0, 32'h1004,0,0,0));
      rows.push_back(mk(0,0,1,SEQ,0,0,0, 32'h1008,0,0,0));
      rows.push_back(mk(0,0,1,SEQ,0,0,0, 32'h100C,0,0,0));
      foreach (rows[k]) begin
         apply(rows[k]);
         @(posedge clk); #1;
         e = exp_q.pop_front(); checks++;
         if ({pc, redirect, ras_count, ras_miss} !== e) begin
            errors++;
            $display("FAIL reset[%0d]: got pc=%h redir=%b cnt=%0d miss=%b want pc=%h redir=%b cnt=%0d miss=%b",
                     k, pc, redirect, ras_count, ras_miss, e.pc, e.redir, e.cnt, e.miss);
         end
      end
      checks++;
      if (pc_plus4 !== 32'h1010) begin
         errors++;
         $display("FAIL pc_plus4: got %h want %h", pc_plus4, 32'h1010);
      end
   endtask

   task automatic test_jump();
      exp_t e;
      rows = {};
      rows.push_back(mk(1,0,0,SEQ,0,0,0, 32'h1000,0,0,0));
      rows.push_back(mk(0,0,1,JR,0,0,32'hA000_0012, 32'hA000_0010,1,0,0));
      rows.push_back(mk(0,0,1,JUMP,26'h123,0,0, 32'hA000_048C,1,0,0));
      rows.push_back(mk(0,0,1,SEQ,0,0,0, 32'hA000_0490,0,0,0));
      // pc+4 would cross into the next region; region must come from pc.
      rows.push_back(mk(0,0,1,JR,0,0,32'h0FFF_FFFC, 32'h0FFF_FFFC,1,0,0));
      rows.push_back(mk(0,0,1,JUMP,26'h0,0,0, 32'h0000_0000,1,0,0));
      rows.push_back(mk(0,0,1,3'd6,26'h55,1,32'h900, 32'h0000_0004,0,0,0));
      rows.push_back(mk(0,0,0,JR,0,0,32'h500, 32'h0000_0008,0,0,0));
      foreach (rows[k]) begin
         apply(rows[k]);
         @(posedge clk); #1;
         e = exp_q.pop_front(); checks++;
         if ({pc, redirect, ras_count, ras_miss} !== e) begin
            errors++;
            $display("FAIL jump[%0d]: got pc=%h redir=%b cnt=%0d miss=%b want pc=%h redir=%b cnt=%0d miss=%b",
                     k, pc, redirect, ras_count, ras_miss, e.pc, e.redir, e.cnt, e.miss);
         end
      end
   endtask

   task automatic test_branch();
      exp_t e;
      rows = {};
      rows.push_back(mk(1,0,0,SEQ,0,0,0, 32'h1000,0,0,0));
      rows.push_back(mk(0,0,1,JR,0,0,32'h100, 32'h100,1,0,0));
      rows.push_back(mk(0,0,1,BR,26'h2A_FFFE,1,0, 32'h0FC,1,0,0));
      rows.push_back(mk(0,0,1,JR,0,0,32'h100, 32'h100,1,0,0));
      rows.push_back(mk(0,0,1,BR,26'h2A_FFFE,0,0, 32'h104,0,0,0));
      rows.push_back(mk(0,0,1,JR,0,0,32'hFFFF_FFFC, 32'hFFFF_FFFC,1,0,0));
      rows.push_back(mk(0,0,1,BR,26'h3FF_0001,1,0, 32'h0000_0004,1,0,0));
      rows.push_back(mk(0,0,0,BR,26'h0_0010,1,0, 32'h0000_0008,0,0,0));
      foreach (rows[k]) begin
         apply(rows[k]);
         @(posedge clk); #1;
         e = exp_q.pop_front(); checks++;
         if ({pc, redirect, ras_count, ras_miss} !== e) begin
            errors++;
            $display("FAIL branch[%0d]: got pc=%h redir=%b cnt=%0d miss=%b want pc=%h redir=%b cnt=%0d miss=%b",
                     k, pc, redirect, ras_count, ras_miss, e.pc, e.redir, e.cnt, e.miss);
         end
      end
   endtask

   task automatic test_call_return();
      exp_t e;
      rows = {};
      rows.push_back(mk(1,0,0,SEQ,0,0,0, 32'h1000,0,0,0));
      rows.push_back(mk(0,0,1,JR,0,0,32'h100, 32'h100,1,0,0));
      rows.push_back(mk(0,0,1,JAL,26'h80,0,0, 32'h200,1,1,0));
      rows.push_back(mk(0,0,1,JAL,26'hC0,0,0, 32'h300,1,2,0));
      rows.push_back(mk(0,0,1,JAL,26'h400,0,0, 32'h1000,1,3,0));
      rows.push_back(mk(0,0,1,RET,0,0,32'hDEAD_0000, 32'h304,1,2,0));
      rows.push_back(mk(0,0,1,RET,0,0,32'hDEAD_0000, 32'h204,1,1,0));
      rows.push_back(mk(0,0,1,RET,0,0,32'hDEAD_0000, 32'h104,1,0,0));
      foreach (rows[k]) begin
         apply(rows[k]);
         @(posedge clk); #1;
         e = exp_q.pop_front(); checks++;
         if ({pc, redirect, ras_count, ras_miss} !== e) begin
            errors++;
            $display("FAIL call_ret[%0d]: got pc=%h redir=%b cnt=%0d miss=%b want pc=%h redir=%b cnt=%0d miss=%b",
                     k, pc, redirect, ras_count, ras_miss, e.pc, e.redir, e.cnt, e.miss);
         end
      end
   endtask

   task automatic test_ras_overflow();
      exp_t        e;
      logic [31:0] tgt, link [5];
      rows = {};
      rows.push_back(mk(1,0,0,SEQ,0,0,0, 32'h1000,0,0,0));
      for (int k = 0; k < 5; k++) begin
         tgt     = 32'h2000 + 32'(k) * 32'h100;
         link[k] = (k == 0) ? 32'h1004 : 32'h2000 + 32'(k-1) * 32'h100 + 32'h4;
         rows.push_back(mk(0,0,1,JAL,tgt[27:2],0,0, tgt,1,3'((k < 4) ? k+1 : 4),0));
      end
      // Oldest link (0x1004) was overwritten; the newest four come back.
      for (int k = 4; k >= 1; k--)
         rows.push_back(mk(0,0,1,RET,0,0,32'h0, link[k],1,3'(k-1),0));
      rows.push_back(mk(0,0,1,RET,0,0,32'h0000_0803, 32'h800,1,0,1));
      rows.push_back(mk(0,0,1,SEQ,0,0,0, 32'h804,0,0,0));
      foreach (rows[k]) begin
         apply(rows[k]);
         @(posedge clk); #1;
         e = exp_q.pop_front(); checks++;
         if ({pc, redirect, ras_count, ras_miss} !== e) begin
            errors++;
            $display("FAIL ras_ovf[%0d]: got pc=%h redir=%b cnt=%0d miss=%b want pc=%h redir=%b cnt=%0d miss=%b",
                     k, pc, redirect, ras_count, ras_miss, e.pc, e.redir, e.cnt, e.miss);
         end
      end
   endtask

   task automatic test_stall_reset();
      exp_t e;
      rows = {};
      rows.push_back(mk(1,0,0,SEQ,0,0,0, 32'h1000,0,0,0));
      rows.push_back(mk(0,1,1,JAL,26'hC00,0,0, 32'h1000,0,0,0));
      rows.push_back(mk(0,1,1,RET,0,0,32'h40, 32'h1000,0,0,0));
      rows.push_back(mk(0,0,1,JAL,26'hC00,0,0, 32'h3000,1,1,0));
      rows.push_back(mk(0,1,1,SEQ,0,0,0, 32'h3000,1,1,0));
      rows.push_back(mk(1,1,1,JUMP,26'h123,0,0, 32'h1000,0,0,0));
      // RAS must be logically empty after reset: RET falls back to rs_val.
      rows.push_back(mk(0,0,1,RET,0,0,32'h41, 32'h40,1,0,1));
      rows.push_back(mk(0,1,1,SEQ,0,0,0, 32'h40,1,0,0));
      foreach (rows[k]) begin
         apply(rows[k]);
         @(posedge clk); #1;
         e = exp_q.pop_front(); checks++;
         if ({pc, redirect, ras_count, ras_miss} !== e) begin
            errors++;
            $display("FAIL stall_rst[%0d]: got pc=%h redir=%b cnt=%0d miss=%b want pc=%h redir=%b cnt=%0d miss=%b",
                     k, pc, redirect, ras_count, ras_miss, e.pc, e.redir, e.cnt, e.miss);
         end
      end
   endtask

   initial begin
      test_reset();
      test_jump();
      test_branch();
      test_call_return();
      test_ras_overflow();
      test_stall_reset();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard: got %0d leftover entries want 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
